mac_ram_reader: RTL

MAC_RAM_READER -- requirements
Module: mac_ram_reader

---
 rtl/mac_pkg.sv | 26 ++
 rtl/word2byte_ser.sv | 52 +++++
 rtl/mac_ram_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  mac_pkg
//  Shared constants and reader state encoding for the MAC bank reader.
//  Revision: 1.0
// ============================================================================
package mac_pkg;

    localparam int MAC_ADDR_W         = 9;
    localparam int MAC_WORDS          = 1 << MAC_ADDR_W;
    localparam int MAC_DATA_W         = 32;
    localparam int MAC_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTER = 3'd1,
        ST_ADDR  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_EXIT  = 3'd5,
        ST_CLR   = 3'd6,
        ST_DONE  = 3'd7
    } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/word2byte_ser.sv
`default_nettype none
// ============================================================================
//  word2byte_ser
//  Loads a 32-bit word and streams it LSB-first as bytes over valid/ready.
//  Revision: 1.0
// ============================================================================
module word2byte_ser
    import mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [MAC_DATA_W-1:0] word,
    output logic [7:0]            data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  last
);

    localparam int CNT_W = $clog2(MAC_BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MAC_BYTES_PER_WORD - 1);

    logic [MAC_DATA_W-1:0] shreg;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            byte_cnt <= '0;
            valid_q  <= 1'b1;
        end else if (valid_q && ready) begin
            // The final byte is left in place so out_data does not glitch when valid drops.
            if (byte_cnt == LAST_BYTE) begin
                valid_q <= 1'b0;
            end else begin
                shreg    <= shreg >> 8;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    assign data  = shreg[7:0];
    assign valid = valid_q;
    assign last  = (byte_cnt == LAST_BYTE);

endmodule
`default_nettype wire

// File: rtl/mac_ram_reader.sv
`default_nettype none
// ============================================================================
//  mac_ram_reader
//  Dumps the whole MAC bank as a byte stream; MAC_READER_AUTOCLR_EN adds a
//  one-cycle bank clear after each dump.
//  Revision: 1.0
// ============================================================================
module mac_ram_reader
    import mac_pkg::*;
#(
    parameter int ADDR_W = MAC_ADDR_W,
    parameter int RD_LAT = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  read,
    output logic [ADDR_W-1:0]     rAddr,
    input  logic [MAC_DATA_W-1:0] rData,
    output logic                  clr,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'(RD_LAT - 1);

    reader_state_t     state;
    reader_state_t     state_nxt;
    logic [ADDR_W-1:0] counter;
    logic [LAT_W-1:0]  lat_cnt;
    logic              ser_load;
    logic              ser_last;
    logic              word_sent;

    assign word_sent = (state == ST_SEND) && out_valid && out_ready && ser_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state == ST_ADDR) ? lat_cnt + 1'b1 : '0;
            if (state == ST_IDLE && start) begin
                counter <= '0;
            end else if (word_sent && counter != LAST_ADDR) begin
                counter <= counter + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ENTER;
            ST_ENTER: state_nxt = ST_ADDR;
            ST_ADDR:  if (lat_cnt == LAT_END) state_nxt = ST_CAPT;
            ST_CAPT: begin
                ser_load  = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (word_sent) state_nxt = (counter == LAST_ADDR) ? ST_EXIT : ST_ADDR;
            end
`ifdef MAC_READER_AUTOCLR_EN
            ST_EXIT:  state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_DONE;
`else
            ST_EXIT:  state_nxt = ST_DONE;
`endif
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // read spans ENTER..SEND so the bank stays out of its wait state for the whole dump.
    assign read  = (state == ST_ENTER) || (state == ST_ADDR) ||
                   (state == ST_CAPT)  || (state == ST_SEND);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign rAddr = counter;

`ifdef MAC_READER_AUTOCLR_EN
    assign clr = (state == ST_CLR);
`else
    assign clr = 1'b0;
`endif

    word2byte_ser u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load),
        .word  (rData),
        .data  (out_data),
        .valid (out_valid),
        .ready (out_ready),
        .last  (ser_last)
    );

endmodule
`default_nettype wire
